// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants for the core, its block server and their benches.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BLK_WORDS = 16;
  localparam int unsigned DIG_WORDS = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [BLK_WORDS-1:0] blk_vec_t;
  typedef word_t [DIG_WORDS-1:0] dig_vec_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    RESULT    = 2'd3
  } state_t;

  // Index 0 is H0.
  localparam dig_vec_t SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

endpackage

// File: rtl/sha256_msg_ram.sv
// Message RAM: one host write port and sixteen registered read taps that
// wrap modulo DEPTH, giving the core a whole 512-bit block per cycle.
module sha256_msg_ram
  import sha256_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output blk_vec_t      rdata
);

  word_t         mem      [DEPTH];
  logic [AW-1:0] tap_addr [BLK_WORDS];

  // Address arithmetic is AW bits wide, so the wrap is free.
  always_comb begin
    for (int j = 0; j < BLK_WORDS; j++) begin
      tap_addr[j] = raddr + AW'(j);
    end
  end

  // Storage deliberately has no reset so a host-loaded message survives one.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      for (int j = 0; j < BLK_WORDS; j++) begin
        rdata[j] <= mem[tap_addr[j]];
      end
    end
  end

endmodule

// File: rtl/sha256_block_server.sv
// Host-side memory and sequencer for one SHA-256 core: serves the message
// block, kicks off one hash per host_go and captures the digest write-back.
module sha256_block_server
  import sha256_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  word_t         host_wdata,
  input  logic          host_go,
  output logic          host_busy,
  output logic          res_valid,
  input  logic [2:0]    res_idx,
  output word_t         res_data,
  output logic          error,
  output logic          start,
  input  logic          done,
  output dig_vec_t      hash,
  input  logic [15:0]   mem_addr,
  input  logic          mem_we,
  input  dig_vec_t      mem_write_data,
  output blk_vec_t      mem_read_data
);

  localparam int unsigned CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  dig_vec_t         result;
  logic             captured;
  logic             host_open_c;
  logic             unused_addr_bits;

  // Only the low AW address bits select a word; the rest wrap away.
  assign unused_addr_bits = ^mem_addr;

  assign host_open_c = (state == IDLE) || (state == RESULT);
  assign hash        = SHA256_IV;
  assign res_data    = result[res_idx];

  sha256_msg_ram #(
    .DEPTH (DEPTH)
  ) u_msg_ram (
    .clk   (clk),
    .reset (reset),
    .we    (host_we && host_open_c),
    .waddr (host_addr),
    .wdata (host_wdata),
    .raddr (mem_addr[AW-1:0]),
    .rdata (mem_read_data)
  );

  // Run sequencer; the wait counter saturates and restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      result    <= '0;
      captured  <= 1'b0;
      host_busy <= 1'b0;
      res_valid <= 1'b0;
      error     <= 1'b0;
      start     <= 1'b0;
    end else begin
      start <= 1'b0;
      cnt   <= (cnt == '1) ? cnt : cnt + CNT_W'(1);
      case (state)
        IDLE, RESULT: begin
          if (host_go) begin
            state     <= WAIT_BUSY;
            cnt       <= '0;
            captured  <= 1'b0;
            res_valid <= 1'b0;
            error     <= 1'b0;
            start     <= 1'b1;
            host_busy <= 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!done) begin
            state <= WAIT_DONE;
            cnt   <= '0;
          end else if (cnt == CNT_LIMIT) begin
            state     <= IDLE;
            cnt       <= '0;
            error     <= 1'b1;
            host_busy <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (mem_we) begin
            result   <= mem_write_data;
            captured <= 1'b1;
          end
          // A write landing in the same cycle as done still counts.
          if (done) begin
            cnt       <= '0;
            host_busy <= 1'b0;
            if (captured || mem_we) begin
              state     <= RESULT;
              res_valid <= 1'b1;
            end else begin
              state <= IDLE;
              error <= 1'b1;
            end
          end else if (cnt == CNT_LIMIT) begin
            state     <= IDLE;
            cnt       <= '0;
            error     <= 1'b1;
            host_busy <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          host_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_server.sv
// Directed bench for sha256_block_server with a scripted core stub and a
// scoreboard of expected read words and digest words.
module tb_sha256_block_server;
  import sha256_pkg::*;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          host_we;
  logic [AW-1:0] host_addr;
  word_t         host_wdata;
  logic          host_go;
  logic          host_busy;
  logic          res_valid;
  logic [2:0]    res_idx;
  word_t         res_data;
  logic          error;
  logic          start;
  logic          done;
  dig_vec_t      hash;
  logic [15:0]   mem_addr;
  logic          mem_we;
  dig_vec_t      mem_write_data;
  blk_vec_t      mem_read_data;

  int    total = 0;
  int    bad = 0;
  int    start_cnt = 0;
  word_t exp_q[$];
  word_t model_ram [DEPTH];

  always #5 clk = ~clk;

  sha256_block_server #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_go        (host_go),
    .host_busy      (host_busy),
    .res_valid      (res_valid),
    .res_idx        (res_idx),
    .res_data       (res_data),
    .error          (error),
    .start          (start),
    .done           (done),
    .hash           (hash),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input word_t obs, input word_t expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_pop(input string tag, input word_t obs);
    word_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic read_req(input logic [15:0] a);
    mem_addr = a;
    for (int j = 0; j < 16; j++) exp_q.push_back(model_ram[(int'(a) + j) % DEPTH]);
  endtask

  task automatic check_read(input string tag);
    for (int j = 0; j < 16; j++) chk_pop(tag, mem_read_data[j]);
  endtask

  task automatic check_digest(input string tag);
    for (int i = 0; i < 8; i++) begin
      res_idx = 3'(i);
      #1;
      chk_pop(tag, res_data);
    end
  endtask

  initial begin
    dig_vec_t wd;
    int s0;
    int n;

    reset = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_go = 1'b0;
    res_idx = '0; done = 1'b1; mem_addr = '0; mem_we = 1'b0; mem_write_data = '0;
    repeat (3) step();
    chk1("rst_busy", host_busy, 1'b0);
    chk1("rst_valid", res_valid, 1'b0);
    chk1("rst_error", error, 1'b0);
    chk1("rst_start", start, 1'b0);
    chk("rst_rd0", mem_read_data[0], 32'h0);
    chk("rst_rd15", mem_read_data[15], 32'h0);
    chk("rst_res", res_data, 32'h0);
    chk("iv_h0", hash[0], 32'h6a09e667);
    chk("iv_h7", hash[7], 32'h5be0cd19);
    reset = 1'b0;
    step();

    // Load ram[i] = i
    for (int i = 0; i < DEPTH; i++) begin
      host_we = 1'b1; host_addr = AW'(i); host_wdata = word_t'(i);
      model_ram[i] = word_t'(i);
      step();
    end
    host_we = 1'b0;

    read_req(16'd60); step(); check_read("rd_wrap60");
    read_req(16'd5); step(); check_read("rd_5");
    read_req(16'hFFFF); step(); check_read("rd_hi_bits");

    // Nominal run
    host_go = 1'b1; step(); host_go = 1'b0;
    chk1("nom_start", start, 1'b1);
    chk1("nom_busy", host_busy, 1'b1);
    done = 1'b0; step();
    chk1("nom_start_pulse", start, 1'b0);
    chk1("nom_busy2", host_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      wd[i] = word_t'(i + 1) * 32'h11111111;
      exp_q.push_back(wd[i]);
    end
    mem_we = 1'b1; mem_write_data = wd; step(); mem_we = 1'b0;
    repeat (4) step();
    done = 1'b1; step();
    chk1("nom_valid", res_valid, 1'b1);
    chk1("nom_busy_off", host_busy, 1'b0);
    chk1("nom_error", error, 1'b0);
    check_digest("nom_digest");

    // Missing write-back
    host_go = 1'b1; step(); host_go = 1'b0;
    chk1("miss_valid_cleared", res_valid, 1'b0);
    done = 1'b0; step();
    repeat (3) step();
    done = 1'b1; step();
    chk1("miss_error", error, 1'b1);
    chk1("miss_valid", res_valid, 1'b0);
    chk1("miss_busy", host_busy, 1'b0);
    step();
    chk1("miss_idle", host_busy, 1'b0);

    // Write and go in the same IDLE cycle
    host_we = 1'b1; host_addr = AW'(20); host_wdata = 32'h12345678; host_go = 1'b1;
    model_ram[20] = 32'h12345678;
    step(); host_we = 1'b0; host_go = 1'b0;
    chk1("wg_error_clr", error, 1'b0);
    chk1("wg_start", start, 1'b1);
    read_req(16'd18); step(); check_read("wg_read");
    done = 1'b0; step();
    for (int i = 0; i < 8; i++) wd[i] = 32'h5000_0000 + word_t'(i);
    mem_we = 1'b1; mem_write_data = wd; step(); mem_we = 1'b0;
    done = 1'b1; step();
    chk1("wg_valid", res_valid, 1'b1);

    // Lockout during WAIT_DONE, plus last-write-wins
    s0 = start_cnt;
    host_go = 1'b1; step(); host_go = 1'b0;
    done = 1'b0; step();
    host_we = 1'b1; host_addr = AW'(3); host_wdata = 32'hDEADBEEF; host_go = 1'b1;
    step(); host_we = 1'b0; host_go = 1'b0;
    chk1("lock_no_start", start, 1'b0);
    chk1("lock_busy", host_busy, 1'b1);
    for (int i = 0; i < 8; i++) wd[i] = 32'hA000_0000 + word_t'(i) * 32'h01010101;
    mem_we = 1'b1; mem_write_data = wd; step();
    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'hB000_0000 + word_t'(i) * 32'h00100010;
      exp_q.push_back(wd[i]);
    end
    mem_write_data = wd; step(); mem_we = 1'b0;
    done = 1'b1; step();
    chk1("lock_valid", res_valid, 1'b1);
    check_digest("lock_digest");
    chk("lock_start_count", word_t'(start_cnt - s0), 32'd1);
    read_req(16'd0); step(); check_read("lock_ram3");

    // Host write in RESULT keeps res_valid
    host_we = 1'b1; host_addr = AW'(40); host_wdata = 32'hCAFEF00D;
    model_ram[40] = 32'hCAFEF00D;
    step(); host_we = 1'b0;
    chk1("result_wr_valid", res_valid, 1'b1);

    // Timeout in WAIT_BUSY
    host_go = 1'b1; step(); host_go = 1'b0;
    chk1("to_valid_clr", res_valid, 1'b0);
    chk1("to_busy", host_busy, 1'b1);
    n = 0;
    while (error !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk("to_cycles", word_t'(n), word_t'(TIMEOUT + 1));
    chk1("to_error", error, 1'b1);
    chk1("to_busy_off", host_busy, 1'b0);
    host_go = 1'b1; step(); host_go = 1'b0;
    chk1("to_restart_err", error, 1'b0);
    chk1("to_restart_start", start, 1'b1);
    chk1("to_restart_busy", host_busy, 1'b1);

    // Reset in WAIT_DONE
    done = 1'b0; step();
    for (int i = 0; i < 8; i++) wd[i] = 32'h7700_0000 + word_t'(i);
    mem_we = 1'b1; mem_write_data = wd; step(); mem_we = 1'b0;
    reset = 1'b1;
    #1;
    chk1("mrst_busy", host_busy, 1'b0);
    chk1("mrst_valid", res_valid, 1'b0);
    chk1("mrst_start", start, 1'b0);
    chk1("mrst_error", error, 1'b0);
    res_idx = 3'd2; #1;
    chk("mrst_res", res_data, 32'h0);
    chk("mrst_rd0", mem_read_data[0], 32'h0);
    step();
    reset = 1'b0; done = 1'b1;
    read_req(16'd36); step(); check_read("mrst_ram");
    read_req(16'd14); step(); check_read("mrst_ram2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
